// File: rtl/sprite_layer_mixer.sv
// Two-stage sprite compositor: NUM_SPR double-buffered sprite layers over a background, lowest index on top.
// Optional macro SPR_HFLIP_EN adds a per-layer horizontal flip bit (cfg_flip) and the spr_col column-offset output.
module sprite_layer_mixer #(
    parameter int              NUM_SPR   = 8,
    parameter int              PIX_W     = 16,
    parameter int              COORD_W   = 10,
    parameter logic [PIX_W-1:0] KEY_COLOR = 16'h0E3B,
    localparam int             IDX_W     = $clog2(NUM_SPR),
    localparam int             SEL_W     = $clog2(NUM_SPR + 1)
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     frame_start,
    input  logic                     pix_valid,
    input  logic [COORD_W-1:0]       DrawX,
    input  logic [COORD_W-1:0]       DrawY,
    input  logic [PIX_W-1:0]         bg_pix,
    input  logic [NUM_SPR*PIX_W-1:0] spr_pix,
    input  logic                     cfg_we,
    input  logic [IDX_W-1:0]         cfg_idx,
    input  logic [COORD_W-1:0]       cfg_x,
    input  logic [COORD_W-1:0]       cfg_y,
    input  logic [7:0]               cfg_w,
    input  logic [7:0]               cfg_h,
    input  logic                     cfg_en,
`ifdef SPR_HFLIP_EN
    input  logic                     cfg_flip,
    output logic [NUM_SPR*8-1:0]     spr_col,
`endif
    output logic [PIX_W-1:0]         out_pix,
    output logic                     out_valid,
    output logic [SEL_W-1:0]         out_sel,
    output logic [NUM_SPR-1:0]       collide
);

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [7:0]         w;
        logic [7:0]         h;
        logic               en;
`ifdef SPR_HFLIP_EN
        logic               flip;
`endif
    } desc_t;

    desc_t pending [NUM_SPR];
    desc_t active  [NUM_SPR];
    desc_t cfg_desc;

    always_comb begin
        cfg_desc.x  = cfg_x;
        cfg_desc.y  = cfg_y;
        cfg_desc.w  = cfg_w;
        cfg_desc.h  = cfg_h;
        cfg_desc.en = cfg_en;
`ifdef SPR_HFLIP_EN
        cfg_desc.flip = cfg_flip;
`endif
    end

    // NOTE: both descriptor banks are small register arrays, not RAM, so they can take the async
    // reset; that is what guarantees every layer starts disabled.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_SPR; i++) begin
                pending[i] <= '0;
                active[i]  <= '0;
            end
        end else begin
            // NOTE: non-blocking assignment makes the bank copy read pending as it was before
            // any write on the same edge, so a coincident write waits for the next frame.
            if (frame_start) begin
                for (int i = 0; i < NUM_SPR; i++)
                    active[i] <= pending[i];
            end
            if (cfg_we && (32'(cfg_idx) < NUM_SPR))
                pending[cfg_idx] <= cfg_desc;
        end
    end

    logic [NUM_SPR-1:0] hit;

    for (genvar i = 0; i < NUM_SPR; i++) begin : g_layer
        logic [COORD_W:0]   x_end;
        logic [COORD_W:0]   y_end;
        logic [PIX_W-1:0]   pix;

        assign pix   = spr_pix[i*PIX_W +: PIX_W];
        // One extra bit keeps x+w from wrapping to the left edge of the screen.
        assign x_end = {1'b0, active[i].x} + (COORD_W+1)'(active[i].w);
        assign y_end = {1'b0, active[i].y} + (COORD_W+1)'(active[i].h);

        assign hit[i] = active[i].en
                      && (DrawX >= active[i].x) && ({1'b0, DrawX} < x_end)
                      && (DrawY >= active[i].y) && ({1'b0, DrawY} < y_end)
                      && (pix != KEY_COLOR);

`ifdef SPR_HFLIP_EN
        logic [7:0] col_off;
        assign col_off = 8'(DrawX - active[i].x);
        assign spr_col[i*8 +: 8] = active[i].flip ? (active[i].w - 8'd1 - col_off) : col_off;
`endif
    end

    logic                     s1_valid;
    logic [NUM_SPR-1:0]       s1_hit;
    logic [NUM_SPR*PIX_W-1:0] s1_spr;
    logic [PIX_W-1:0]         s1_bg;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_valid <= 1'b0;
            s1_hit   <= '0;
        end else begin
            s1_valid <= pix_valid;
            s1_hit   <= hit;
        end
    end

    // Pixel data is qualified by s1_valid, so it needs no reset.
    always_ff @(posedge Clk) begin
        s1_spr <= spr_pix;
        s1_bg  <= bg_pix;
    end

    logic [PIX_W-1:0]   win_pix;
    logic [SEL_W-1:0]   win_sel;
    logic [NUM_SPR-1:0] collide_nxt;

    // NOTE: every always_comb output gets a default before any condition, so no latch is inferred.
    always_comb begin
        win_pix = s1_bg;
        win_sel = SEL_W'(NUM_SPR);
        // Walking from the top index down leaves the lowest-index hit as the winner.
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (s1_hit[i]) begin
                win_pix = s1_spr[i*PIX_W +: PIX_W];
                win_sel = SEL_W'(i);
            end
        end
    end

    always_comb begin
        collide_nxt = frame_start ? '0 : collide;
        // Applied after the clear so an overlap on the frame_start cycle lands in the new frame.
        if (s1_valid && s1_hit[0])
            collide_nxt = collide_nxt | {s1_hit[NUM_SPR-1:1], 1'b0};
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_valid <= 1'b0;
            out_pix   <= '0;
            out_sel   <= '0;
            collide   <= '0;
        end else begin
            out_valid <= s1_valid;
            collide   <= collide_nxt;
            if (s1_valid) begin
                out_pix <= win_pix;
                out_sel <= win_sel;
            end
        end
    end

endmodule

// File: tb/tb_sprite_layer_mixer.sv
// Directed self-checking bench for sprite_layer_mixer with the default parameters (8 layers, RGB565, 10-bit coords).
module tb_sprite_layer_mixer;

    localparam int NUM_SPR = 8;
    localparam int PIX_W   = 16;
    localparam int COORD_W = 10;
    localparam logic [15:0] KEY = 16'h0E3B;
    localparam logic [15:0] BG  = 16'h1234;

    logic                     Clk = 1'b0;
    logic                     Reset;
    logic                     frame_start;
    logic                     pix_valid;
    logic [COORD_W-1:0]       DrawX;
    logic [COORD_W-1:0]       DrawY;
    logic [PIX_W-1:0]         bg_pix;
    logic [NUM_SPR*PIX_W-1:0] spr_pix;
    logic                     cfg_we;
    logic [2:0]               cfg_idx;
    logic [COORD_W-1:0]       cfg_x;
    logic [COORD_W-1:0]       cfg_y;
    logic [7:0]               cfg_w;
    logic [7:0]               cfg_h;
    logic                     cfg_en;
    logic [PIX_W-1:0]         out_pix;
    logic                     out_valid;
    logic [3:0]               out_sel;
    logic [NUM_SPR-1:0]       collide;
`ifdef SPR_HFLIP_EN
    logic                     cfg_flip;
    logic [NUM_SPR*8-1:0]     spr_col;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    sprite_layer_mixer #(
        .NUM_SPR(NUM_SPR), .PIX_W(PIX_W), .COORD_W(COORD_W), .KEY_COLOR(KEY)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pix_valid(pix_valid),
        .DrawX(DrawX), .DrawY(DrawY), .bg_pix(bg_pix), .spr_pix(spr_pix),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y),
        .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_en(cfg_en),
`ifdef SPR_HFLIP_EN
        .cfg_flip(cfg_flip), .spr_col(spr_col),
`endif
        .out_pix(out_pix), .out_valid(out_valid), .out_sel(out_sel), .collide(collide)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic write_desc(input int idx, input int x, input int y, input int w, input int h,
                              input bit en, input bit with_frame);
        cfg_idx     = 3'(idx);
        cfg_x       = COORD_W'(x);
        cfg_y       = COORD_W'(y);
        cfg_w       = 8'(w);
        cfg_h       = 8'(h);
        cfg_en      = en;
        cfg_we      = 1'b1;
        frame_start = with_frame;
        step();
        cfg_we      = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    // Presents one valid pixel and returns once its result has reached the outputs.
    task automatic drive_pixel(input int x, input int y);
        DrawX     = COORD_W'(x);
        DrawY     = COORD_W'(y);
        pix_valid = 1'b1;
        step();
        pix_valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step();
        step();
        n_checks++;
        if ({out_valid, out_sel, out_pix, collide} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b sel=%0d pix=%h collide=%b, want all zero",
                     out_valid, out_sel, out_pix, collide);
        end
        Reset = 1'b0;
        step();
    endtask

    task automatic test_background_stream();
        bit pat [8] = '{1, 1, 0, 1, 0, 0, 1, 1};
        bit exp_v;
        logic [15:0] last_pix = 16'h0000;
        for (int c = 0; c < 10; c++) begin
            DrawX     = COORD_W'(c * 3);
            DrawY     = 10'd400;
            pix_valid = (c < 8) ? pat[c] : 1'b0;
            step();
            exp_v = (c >= 1 && c <= 8) ? pat[c-1] : 1'b0;
            if (exp_v) last_pix = BG;
            n_checks++;
            if (out_valid !== exp_v || out_pix !== last_pix || (exp_v && out_sel !== 4'd8)) begin
                n_fail++;
                $display("FAIL bg_stream[%0d]: got valid=%b pix=%h sel=%0d, want valid=%b pix=%h sel=8",
                         c, out_valid, out_pix, out_sel, exp_v, last_pix);
            end
        end
    endtask

    task automatic test_single_layer();
        int          xs [6] = '{100, 131, 132,  99, 100, 100};
        int          ys [6] = '{ 50,  81,  50,  50,  82,  49};
        logic [3:0]  ss [6] = '{4'd2, 4'd2, 4'd8, 4'd8, 4'd8, 4'd8};
        logic [15:0] ps [6] = '{16'hF800, 16'hF800, BG, BG, BG, BG};
        spr_pix[2*16 +: 16] = 16'hF800;
        write_desc(2, 100, 50, 32, 32, 1'b1, 1'b0);
        pulse_frame();
        for (int k = 0; k < 6; k++) begin
            drive_pixel(xs[k], ys[k]);
            n_checks++;
            if ({out_valid, out_sel, out_pix} !== {1'b1, ss[k], ps[k]}) begin
                n_fail++;
                $display("FAIL layer2 (%0d,%0d): got valid=%b sel=%0d pix=%h, want valid=1 sel=%0d pix=%h",
                         xs[k], ys[k], out_valid, out_sel, out_pix, ss[k], ps[k]);
            end
        end
    endtask

    task automatic test_priority();
        write_desc(1, 190, 190, 20, 20, 1'b1, 1'b0);
        write_desc(3, 195, 195, 20, 20, 1'b1, 1'b0);
        pulse_frame();
        drive_pixel(200, 200);
        n_checks++;
        if ({out_valid, out_sel, out_pix} !== {1'b1, 4'd1, 16'hA001}) begin
            n_fail++;
            $display("FAIL priority_opaque: got sel=%0d pix=%h, want sel=1 pix=a001", out_sel, out_pix);
        end
        spr_pix[1*16 +: 16] = KEY;
        drive_pixel(200, 200);
        n_checks++;
        if ({out_valid, out_sel, out_pix} !== {1'b1, 4'd3, 16'hA003}) begin
            n_fail++;
            $display("FAIL priority_keyed: got sel=%0d pix=%h, want sel=3 pix=a003", out_sel, out_pix);
        end
        spr_pix[1*16 +: 16] = 16'hA001;
    endtask

    task automatic test_write_at_frame_start();
        write_desc(4, 300, 300, 8, 8, 1'b1, 1'b1);
        drive_pixel(302, 302);
        n_checks++;
        if ({out_valid, out_sel, out_pix} !== {1'b1, 4'd8, BG}) begin
            n_fail++;
            $display("FAIL same_cycle_write: got sel=%0d pix=%h, want sel=8 pix=1234", out_sel, out_pix);
        end
        pulse_frame();
        drive_pixel(302, 302);
        n_checks++;
        if ({out_valid, out_sel, out_pix} !== {1'b1, 4'd4, 16'hA004}) begin
            n_fail++;
            $display("FAIL next_frame_write: got sel=%0d pix=%h, want sel=4 pix=a004", out_sel, out_pix);
        end
    endtask

    task automatic test_collision();
        write_desc(0, 10, 10, 16, 16, 1'b1, 1'b0);
        write_desc(5, 20, 20, 16, 16, 1'b1, 1'b0);
        pulse_frame();
        drive_pixel(19, 19);
        n_checks++;
        if ({out_sel, collide} !== {4'd0, 8'h00}) begin
            n_fail++;
            $display("FAIL collide_before: got sel=%0d collide=%b, want sel=0 collide=00000000", out_sel, collide);
        end
        drive_pixel(20, 20);
        n_checks++;
        if ({out_sel, out_pix, collide} !== {4'd0, 16'hA000, 8'h20}) begin
            n_fail++;
            $display("FAIL collide_set: got sel=%0d pix=%h collide=%b, want sel=0 pix=a000 collide=00100000",
                     out_sel, out_pix, collide);
        end
        pulse_frame();
        n_checks++;
        if (collide !== 8'h00) begin
            n_fail++;
            $display("FAIL collide_clear: got collide=%b, want 00000000", collide);
        end
        // Overlap reaching stage 2 on the frame_start cycle must survive the clear.
        DrawX     = 10'd20;
        DrawY     = 10'd20;
        pix_valid = 1'b1;
        step();
        pix_valid   = 1'b0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        n_checks++;
        if (collide !== 8'h20) begin
            n_fail++;
            $display("FAIL collide_set_wins: got collide=%b, want 00100000", collide);
        end
        write_desc(5, 300, 20, 16, 16, 1'b1, 1'b0);
        pulse_frame();
        drive_pixel(20, 20);
        n_checks++;
        if ({out_sel, collide} !== {4'd0, 8'h00}) begin
            n_fail++;
            $display("FAIL collide_no_overlap: got sel=%0d collide=%b, want sel=0 collide=00000000", out_sel, collide);
        end
        drive_pixel(300, 20);
        n_checks++;
        if ({out_sel, out_pix, collide} !== {4'd5, 16'hA005, 8'h00}) begin
            n_fail++;
            $display("FAIL moved_layer5: got sel=%0d pix=%h collide=%b, want sel=5 pix=a005 collide=00000000",
                     out_sel, out_pix, collide);
        end
    endtask

    task automatic test_right_edge();
        int          xs [5] = '{1020, 1023, 0, 11, 1019};
        logic [3:0]  ss [5] = '{4'd6, 4'd6, 4'd8, 4'd8, 4'd8};
        logic [15:0] ps [5] = '{16'hA006, 16'hA006, BG, BG, BG};
        write_desc(6, 1020, 0, 16, 16, 1'b1, 1'b0);
        pulse_frame();
        for (int k = 0; k < 5; k++) begin
            drive_pixel(xs[k], 0);
            n_checks++;
            if ({out_valid, out_sel, out_pix} !== {1'b1, ss[k], ps[k]}) begin
                n_fail++;
                $display("FAIL edge x=%0d: got valid=%b sel=%0d pix=%h, want valid=1 sel=%0d pix=%h",
                         xs[k], out_valid, out_sel, out_pix, ss[k], ps[k]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        DrawX     = 10'd1020;
        DrawY     = 10'd0;
        pix_valid = 1'b1;
        step();
        pix_valid = 1'b0;
        #2 Reset = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, out_sel, out_pix, collide} !== 29'd0) begin
            n_fail++;
            $display("FAIL midframe_reset: got valid=%b sel=%0d pix=%h collide=%b, want all zero",
                     out_valid, out_sel, out_pix, collide);
        end
        step();
        Reset = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flushed_slot: got valid=%b, want 0", out_valid);
        end
        drive_pixel(1020, 0);
        n_checks++;
        if ({out_valid, out_sel, out_pix} !== {1'b1, 4'd8, BG}) begin
            n_fail++;
            $display("FAIL banks_cleared: got valid=%b sel=%0d pix=%h, want valid=1 sel=8 pix=1234",
                     out_valid, out_sel, out_pix);
        end
    endtask

    initial begin
        Reset       = 1'b1;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        DrawX       = '0;
        DrawY       = '0;
        bg_pix      = BG;
        cfg_we      = 1'b0;
        cfg_idx     = '0;
        cfg_x       = '0;
        cfg_y       = '0;
        cfg_w       = '0;
        cfg_h       = '0;
        cfg_en      = 1'b0;
`ifdef SPR_HFLIP_EN
        cfg_flip    = 1'b0;
`endif
        for (int i = 0; i < NUM_SPR; i++)
            spr_pix[i*16 +: 16] = 16'hA000 + 16'(i);

        test_reset();
        test_background_stream();
        test_single_layer();
        test_priority();
        test_write_at_frame_start();
        test_collision();
        test_right_edge();
        test_reset_midframe();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
